// File: rtl/vliw_issue_scoreboard.sv
// vliw_issue_scoreboard: per-register latency countdown scoreboard that stalls a 3-slot VLIW bundle in ID until all its operands and destinations are free
module vliw_issue_scoreboard #(
  parameter int NREGS = 32,
  parameter int RW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_bundle_valid,
  input  logic          i_flush,
  input  logic          i_s0_valid,
  input  logic          i_s0_regwrite,
  input  logic [RW-1:0] i_s0_dest,
  input  logic [RW-1:0] i_s0_src1,
  input  logic [RW-1:0] i_s0_src2,
  input  logic          i_s0_use1,
  input  logic          i_s0_use2,
  input  logic [1:0]    i_s0_lat,
  input  logic          i_s1_valid,
  input  logic          i_s1_regwrite,
  input  logic [RW-1:0] i_s1_dest,
  input  logic [RW-1:0] i_s1_src1,
  input  logic [RW-1:0] i_s1_src2,
  input  logic          i_s1_use1,
  input  logic          i_s1_use2,
  input  logic [1:0]    i_s1_lat,
  input  logic          i_s2_valid,
  input  logic          i_s2_regwrite,
  input  logic [RW-1:0] i_s2_dest,
  input  logic [RW-1:0] i_s2_src1,
  input  logic [RW-1:0] i_s2_src2,
  input  logic          i_s2_use1,
  input  logic          i_s2_use2,
  input  logic [1:0]    i_s2_lat,
  output logic          o_issue,
  output logic          o_pc_write,
  output logic          o_if_id_write,
  output logic          o_id_ex_bubble,
  output logic          o_dup_dest_err,
  output logic [15:0]   o_stall_cycles
);
  logic [1:0]    r_cnt [NREGS];
  logic [1:0]    w_nxt [NREGS];
  logic          r_dup;
  logic [15:0]   r_sc;
  logic [2:0]    w_v, w_rw, w_u1, w_u2, w_wrv, w_blk;
  logic [RW-1:0] w_d [3];
  logic [RW-1:0] w_a [3];
  logic [RW-1:0] w_b [3];
  logic [1:0]    w_l [3];
  logic          w_stall, w_issue, w_dup;
  assign w_v  = {i_s2_valid, i_s1_valid, i_s0_valid};
  assign w_rw = {i_s2_regwrite, i_s1_regwrite, i_s0_regwrite};
  assign w_u1 = {i_s2_use1, i_s1_use1, i_s0_use1};
  assign w_u2 = {i_s2_use2, i_s1_use2, i_s0_use2};
  assign w_d  = '{i_s0_dest, i_s1_dest, i_s2_dest};
  assign w_a  = '{i_s0_src1, i_s1_src1, i_s2_src1};
  assign w_b  = '{i_s0_src2, i_s1_src2, i_s2_src2};
  assign w_l  = '{i_s0_lat, i_s1_lat, i_s2_lat};
  for (genvar k = 0; k < 3; k++) begin : g_slot
    assign w_wrv[k] = w_v[k] & w_rw[k] & (w_d[k] != '0);
    assign w_blk[k] = w_v[k] & ((w_u1[k] & (r_cnt[w_a[k]] != 2'd0)) |
                                (w_u2[k] & (r_cnt[w_b[k]] != 2'd0)) |
                                (w_wrv[k] & (r_cnt[w_d[k]] != 2'd0)));
  end
  assign w_stall = i_bundle_valid & ~i_flush & (|w_blk);
  assign w_issue = i_bundle_valid & ~i_flush & ~w_stall;
  assign w_dup   = w_issue & ((w_wrv[0] & w_wrv[1] & (w_d[0] == w_d[1])) |
                              (w_wrv[0] & w_wrv[2] & (w_d[0] == w_d[2])) |
                              (w_wrv[1] & w_wrv[2] & (w_d[1] == w_d[2])));
  assign o_issue        = w_issue;
  assign o_pc_write     = ~w_stall;
  assign o_if_id_write  = ~w_stall;
  assign o_id_ex_bubble = ~w_issue;
  assign o_dup_dest_err = r_dup;
  assign o_stall_cycles = r_sc;
  // next countdown: decrement, overridden by issue loads; slot 0 wins duplicate dests because it is applied last
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      w_nxt[r] = (r_cnt[r] != 2'd0) ? r_cnt[r] - 2'd1 : 2'd0;
      for (int k = 2; k >= 0; k--)
        if (w_issue && w_wrv[k] && (w_d[k] == RW'(r))) w_nxt[r] = w_l[k];
    end
    w_nxt[0] = 2'd0;
  end
  // scoreboard counters, duplicate-dest pulse and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '{default: 2'd0};
      r_dup <= 1'b0;
      r_sc  <= 16'd0;
    end else begin
      r_cnt <= w_nxt;
      r_dup <= w_dup;
      if (w_stall && r_sc != 16'hFFFF) r_sc <= r_sc + 16'd1;
    end
  end
endmodule

// File: tb/tb_vliw_issue_scoreboard.sv
// tb_vliw_issue_scoreboard: directed vector table, random model comparison, reset-mid-stall and stall counter saturation
module tb_vliw_issue_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bv = 1'b0, fl = 1'b0;
  logic [2:0] v = '0, rw = '0, u1 = '0, u2 = '0;
  logic [2:0][4:0] d = '0, a = '0, b = '0;
  logic [2:0][1:0] lat = '0;
  logic o_issue, o_pcw, o_ifid, o_bub, o_dup;
  logic [15:0] o_sc;
  int n_chk = 0, n_fail = 0;
  longint now;
  longint rdy [32];
  int m_st;
  bit m_dup;

  always #5 clk = ~clk;

  vliw_issue_scoreboard #(.NREGS(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .i_bundle_valid(bv), .i_flush(fl),
    .i_s0_valid(v[0]), .i_s0_regwrite(rw[0]), .i_s0_dest(d[0]), .i_s0_src1(a[0]), .i_s0_src2(b[0]),
    .i_s0_use1(u1[0]), .i_s0_use2(u2[0]), .i_s0_lat(lat[0]),
    .i_s1_valid(v[1]), .i_s1_regwrite(rw[1]), .i_s1_dest(d[1]), .i_s1_src1(a[1]), .i_s1_src2(b[1]),
    .i_s1_use1(u1[1]), .i_s1_use2(u2[1]), .i_s1_lat(lat[1]),
    .i_s2_valid(v[2]), .i_s2_regwrite(rw[2]), .i_s2_dest(d[2]), .i_s2_src1(a[2]), .i_s2_src2(b[2]),
    .i_s2_use1(u1[2]), .i_s2_use2(u2[2]), .i_s2_lat(lat[2]),
    .o_issue(o_issue), .o_pc_write(o_pcw), .o_if_id_write(o_ifid), .o_id_ex_bubble(o_bub),
    .o_dup_dest_err(o_dup), .o_stall_cycles(o_sc)
  );

  typedef struct {
    logic bv, fl;
    logic [2:0] v, rw, u1, u2;
    logic [2:0][4:0] d, a, b;
    logic [2:0][1:0] lat;
    logic ei, ep, ed;
    int es;
  } vec_t;
  vec_t tab [$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference: each register has an absolute cycle from which it is readable/writable
  function automatic bit m_busy(input logic [4:0] r);
    return r != 5'd0 && now < rdy[r];
  endfunction

  function automatic bit m_issue();
    bit blk = 0;
    for (int k = 0; k < 3; k++)
      if (v[k] && ((u1[k] && m_busy(a[k])) || (u2[k] && m_busy(b[k])) || (rw[k] && m_busy(d[k])))) blk = 1;
    return bv && !fl && !blk;
  endfunction

  task automatic m_reset();
    now = 0;
    foreach (rdy[i]) rdy[i] = 0;
    m_st = 0;
    m_dup = 0;
  endtask

  task automatic m_advance();
    bit iss = m_issue();
    bit seen [32];
    bit nd = 0;
    foreach (seen[i]) seen[i] = 0;
    if (bv && !fl && !iss && m_st < 65535) m_st++;
    for (int k = 0; k < 3; k++)
      if (iss && v[k] && rw[k] && d[k] != 5'd0) begin
        if (seen[d[k]]) nd = 1;
        else begin
          seen[d[k]] = 1;
          rdy[d[k]] = now + 1 + longint'(lat[k]);
        end
      end
    m_dup = nd;
    now++;
  endtask

  task automatic cmp(input bit ei, input bit ep, input bit ed, input int es);
    chk("issue", {15'd0, o_issue}, {15'd0, ei});
    chk("pc_write", {15'd0, o_pcw}, {15'd0, ep});
    chk("if_id_write", {15'd0, o_ifid}, {15'd0, ep});
    chk("id_ex_bubble", {15'd0, o_bub}, {15'd0, !ei});
    chk("dup_dest_err", {15'd0, o_dup}, {15'd0, ed});
    chk("stall_cycles", o_sc, es[15:0]);
  endtask

  task automatic step_exp(input bit ei, input bit ep, input bit ed, input int es);
    #2;
    cmp(ei, ep, ed, es);
    m_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step_model();
    bit ei;
    #2;
    ei = m_issue();
    cmp(ei, !(bv && !fl && !ei), m_dup, m_st);
    m_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input vec_t t);
    bv = t.bv; fl = t.fl; v = t.v; rw = t.rw; u1 = t.u1; u2 = t.u2;
    d = t.d; a = t.a; b = t.b; lat = t.lat;
  endtask

  task automatic rand_bundle();
    bv = $urandom_range(0, 9) != 0;
    fl = $urandom_range(0, 9) == 0;
    for (int k = 0; k < 3; k++) begin
      v[k] = $urandom_range(0, 3) != 0;
      rw[k] = $urandom_range(0, 1) == 1;
      u1[k] = $urandom_range(0, 1) == 1;
      u2[k] = $urandom_range(0, 1) == 1;
      d[k] = 5'($urandom_range(0, 7));
      a[k] = 5'($urandom_range(0, 7));
      b[k] = 5'($urandom_range(0, 7));
      lat[k] = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    int guard;
    // directed vectors: {bv,fl,v,rw,u1,u2,d{2,1,0},src1{2,1,0},src2{2,1,0},lat{2,1,0},issue,pc_write,dup,stall_cycles}
    tab.push_back('{1,0,3'b001,3'b001,3'b001,3'b001,{10'd0,5'd3},{10'd0,5'd1},{10'd0,5'd2},6'd0,1,1,0,0});
    tab.push_back('{1,0,3'b001,3'b000,3'b001,3'b000,15'd0,{10'd0,5'd3},15'd0,6'd0,1,1,0,0});
    tab.push_back('{1,0,3'b001,3'b001,3'b000,3'b000,{10'd0,5'd5},15'd0,15'd0,6'd1,1,1,0,0});
    tab.push_back('{1,0,3'b100,3'b000,3'b000,3'b100,15'd0,15'd0,{5'd5,10'd0},6'd0,0,0,0,0});
    tab.push_back('{1,0,3'b100,3'b000,3'b000,3'b100,15'd0,15'd0,{5'd5,10'd0},6'd0,1,1,0,1});
    tab.push_back('{1,0,3'b010,3'b010,3'b000,3'b000,{5'd0,5'd7,5'd0},15'd0,15'd0,{2'd0,2'd2,2'd0},1,1,0,1});
    tab.push_back('{1,0,3'b001,3'b001,3'b000,3'b000,{10'd0,5'd7},15'd0,15'd0,6'd1,0,0,0,1});
    tab.push_back('{1,0,3'b001,3'b001,3'b000,3'b000,{10'd0,5'd7},15'd0,15'd0,6'd1,0,0,0,2});
    tab.push_back('{1,0,3'b001,3'b001,3'b000,3'b000,{10'd0,5'd7},15'd0,15'd0,6'd1,1,1,0,3});
    tab.push_back('{1,0,3'b001,3'b000,3'b001,3'b000,15'd0,{10'd0,5'd7},15'd0,6'd0,0,0,0,3});
    tab.push_back('{1,0,3'b001,3'b000,3'b001,3'b000,15'd0,{10'd0,5'd7},15'd0,6'd0,1,1,0,4});
    tab.push_back('{1,0,3'b011,3'b011,3'b000,3'b000,{5'd0,5'd9,5'd9},15'd0,15'd0,{2'd0,2'd0,2'd2},1,1,0,4});
    tab.push_back('{1,0,3'b001,3'b000,3'b001,3'b000,15'd0,{10'd0,5'd9},15'd0,6'd0,0,0,1,4});
    tab.push_back('{1,0,3'b001,3'b000,3'b001,3'b000,15'd0,{10'd0,5'd9},15'd0,6'd0,0,0,0,5});
    tab.push_back('{1,0,3'b001,3'b000,3'b001,3'b000,15'd0,{10'd0,5'd9},15'd0,6'd0,1,1,0,6});
    tab.push_back('{1,0,3'b001,3'b001,3'b000,3'b000,{10'd0,5'd4},15'd0,15'd0,6'd1,1,1,0,6});
    tab.push_back('{1,1,3'b001,3'b000,3'b001,3'b000,15'd0,{10'd0,5'd4},15'd0,6'd0,0,1,0,6});
    tab.push_back('{1,0,3'b011,3'b001,3'b011,3'b010,15'd0,15'd0,15'd0,6'd3,1,1,0,6});
    tab.push_back('{1,0,3'b001,3'b000,3'b001,3'b001,15'd0,15'd0,15'd0,6'd0,1,1,0,6});
    tab.push_back('{0,0,3'b111,3'b111,3'b111,3'b111,{5'd3,5'd2,5'd1},{5'd4,5'd5,5'd6},{5'd7,5'd8,5'd9},6'd0,0,1,0,6});
    tab.push_back('{1,0,3'b101,3'b101,3'b000,3'b000,{5'd12,5'd0,5'd13},15'd0,15'd0,{2'd3,2'd0,2'd0},1,1,0,6});
    tab.push_back('{1,0,3'b011,3'b000,3'b001,3'b010,15'd0,{10'd0,5'd12},{5'd0,5'd13,5'd0},6'd0,0,0,0,6});
    tab.push_back('{1,0,3'b011,3'b000,3'b001,3'b010,15'd0,{10'd0,5'd12},{5'd0,5'd13,5'd0},6'd0,0,0,0,7});
    tab.push_back('{1,0,3'b011,3'b000,3'b001,3'b010,15'd0,{10'd0,5'd12},{5'd0,5'd13,5'd0},6'd0,0,0,0,8});
    tab.push_back('{1,0,3'b011,3'b000,3'b001,3'b010,15'd0,{10'd0,5'd12},{5'd0,5'd13,5'd0},6'd0,1,1,0,9});

    m_reset();
    #2;
    cmp(0, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    foreach (tab[i]) begin
      set_vec(tab[i]);
      step_exp(tab[i].ei, tab[i].ep, tab[i].ed, tab[i].es);
    end

    // random bundles, held in ID while the model says they are stalled
    for (int i = 0; i < 1000; i++) begin
      if (!(bv && !fl && !m_issue()) || $urandom_range(0, 7) == 0) rand_bundle();
      else fl = $urandom_range(0, 9) == 0;
      step_model();
    end

    // reset while stalled on a multiply
    bv = 1; fl = 0; v = 3'b001; rw = 3'b001; u1 = 0; u2 = 0; d = {10'd0, 5'd6}; lat = 6'd2;
    step_model();
    rw = 0; u1 = 3'b001; a = {10'd0, 5'd6};
    step_model();
    #2;
    chk("stalled_on_mul", {15'd0, o_issue}, 16'd0);
    rst_n = 1'b0;
    #1;
    chk("reset_issue", {15'd0, o_issue}, 16'd1);
    chk("reset_stall_cycles", o_sc, 16'd0);
    chk("reset_dup", {15'd0, o_dup}, 16'd0);
    bv = 0;
    #1;
    chk("reset_idle_issue", {15'd0, o_issue}, 16'd0);
    chk("reset_idle_pc_write", {15'd0, o_pcw}, 16'd1);
    chk("reset_idle_if_id_write", {15'd0, o_ifid}, 16'd1);
    chk("reset_idle_bubble", {15'd0, o_bub}, 16'd1);
    bv = 1;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step_exp(1, 1, 0, 0);

    // saturation: self-dependent latency-4 writer stalls 3 of every 4 cycles
    v = 3'b001; rw = 3'b001; u1 = 3'b001; u2 = 0; d = {10'd0, 5'd10}; a = {10'd0, 5'd10}; lat = 6'd3;
    guard = 0;
    while (o_sc != 16'hFFFF && guard < 90000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("stall_cycles_reached_max", o_sc, 16'hFFFF);
    repeat (8) @(posedge clk);
    #1;
    chk("stall_cycles_saturated", o_sc, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
